// File: rtl/conv_mem_pkg.sv
// Shared constants for the CONV memory-side responder.
// Holds the default widths, the bank-select codes, the FSM state encodings
// and the read-source tags that pick what the read-data outputs show.
package conv_mem_pkg;

    localparam int unsigned DEF_DW         = 20;
    localparam int unsigned DEF_AW         = 12;
    localparam int unsigned DEF_L1_AW      = 10;
    localparam int unsigned DEF_HS_TIMEOUT = 1024;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HS   = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Which source a read-data output shows in the cycle after a read
    typedef logic [1:0] rd_src_t;
    localparam rd_src_t RD_NONE = 2'd0;  // no new read: hold the previous word
    localparam rd_src_t RD_L0   = 2'd1;
    localparam rd_src_t RD_L1   = 2'd2;
    localparam rd_src_t RD_ZERO = 2'd3;  // illegal access: present zero

endpackage

// File: rtl/conv_sync_ram.sv
// Single-write-port, single-registered-read-port synchronous RAM.
// A same-edge read and write to one address returns the old word.
// Ports: clk; rst clears the read register; we/waddr/wdata write port;
//        re/raddr read request; rdata registered read data (holds when re=0).
module conv_sync_ram #(
    parameter int unsigned W  = 20,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; sees the pre-write contents on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_mem_host.sv
// Memory-side responder for the CONV accelerator: image ROM, L0 and L1
// result banks, ready/busy start handshake and a post-run readback port.
// Ports: clk/reset (sync, active-high); start, ld_* preload; ready/busy
//        handshake; iaddr/idata image path; cwr/caddr_wr/cdata_wr,
//        crd/caddr_rd/cdata_rd, csel bank traffic; dump_* readback;
//        done pulse, sticky timeout/bad_access, per-run write counters.
module conv_mem_host
    import conv_mem_pkg::*;
#(
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned L1_AW      = DEF_L1_AW,
    parameter int unsigned HS_TIMEOUT = DEF_HS_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_data,
    output logic             ready,
    input  logic             busy,
    input  logic [AW-1:0]    iaddr,
    output logic [DW-1:0]    idata,
    input  logic             cwr,
    input  logic [AW-1:0]    caddr_wr,
    input  logic [DW-1:0]    cdata_wr,
    input  logic             crd,
    input  logic [AW-1:0]    caddr_rd,
    output logic [DW-1:0]    cdata_rd,
    input  logic [2:0]       csel,
    input  logic             dump_en,
    input  logic             dump_sel,
    input  logic [AW-1:0]    dump_addr,
    output logic [DW-1:0]    dump_data,
    output logic             done,
    output logic             timeout,
    output logic             bad_access,
    output logic [AW:0]      wr_cnt0,
    output logic [L1_AW:0]   wr_cnt1
);

    localparam int unsigned HS_CW = (HS_TIMEOUT > 2) ? $clog2(HS_TIMEOUT) : 1;
    localparam logic [HS_CW-1:0] HS_LAST = HS_CW'((HS_TIMEOUT == 0) ? 0 : HS_TIMEOUT - 1);
    localparam int unsigned C0W = AW + 1;
    localparam int unsigned C1W = L1_AW + 1;

    state_t           state;
    state_t           state_nx;
    logic [HS_CW-1:0] hs_cnt;
    rd_src_t          rd_src;
    rd_src_t          dmp_src;
    logic [DW-1:0]    cdata_hold;
    logic [DW-1:0]    dump_hold;
    logic [DW-1:0]    img_q;
    logic [DW-1:0]    l0_q;
    logic [DW-1:0]    l1_q;

    logic in_run, idle_like, hs_expire, enter_hs;
    logic l1_wr_in_range, l1_rd_in_range;
    logic wr_l0, wr_l1, wr_bad, rd_l0, rd_l1, rd_bad;
    logic dmp_l0, dmp_l1;

    assign in_run    = (state == ST_RUN);
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign hs_expire = (HS_TIMEOUT != 0) && (hs_cnt == HS_LAST);
    assign enter_hs  = (state != ST_HS) && (state_nx == ST_HS);

    // Bank-select decode; anything not a legal L0/L1 access is dropped and flagged
    assign l1_wr_in_range = (caddr_wr[AW-1:L1_AW] == '0);
    assign l1_rd_in_range = (caddr_rd[AW-1:L1_AW] == '0);
    assign wr_l0  = in_run && cwr && (csel == CSEL_L0);
    assign wr_l1  = in_run && cwr && (csel == CSEL_L1) && l1_wr_in_range;
    assign wr_bad = in_run && cwr && !(wr_l0 || wr_l1);
    assign rd_l0  = in_run && crd && (csel == CSEL_L0);
    assign rd_l1  = in_run && crd && (csel == CSEL_L1) && l1_rd_in_range;
    assign rd_bad = in_run && crd && !(rd_l0 || rd_l1);
    assign dmp_l0 = idle_like && dump_en && !dump_sel;
    assign dmp_l1 = idle_like && dump_en && dump_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = ST_HS;
            end
            ST_HS: begin
                if (busy)           state_nx = ST_RUN;
                else if (hs_expire) state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (!busy) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs, status flags, counters and read-source tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            ready      <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            bad_access <= 1'b0;
            wr_cnt0    <= '0;
            wr_cnt1    <= '0;
            hs_cnt     <= '0;
            rd_src     <= RD_NONE;
            dmp_src    <= RD_NONE;
            cdata_hold <= '0;
            dump_hold  <= '0;
        end else begin
            ready      <= (state_nx == ST_HS);
            done       <= in_run && !busy;
            cdata_hold <= cdata_rd;
            dump_hold  <= dump_data;

            if (enter_hs) begin
                hs_cnt     <= '0;
                wr_cnt0    <= '0;
                wr_cnt1    <= '0;
                bad_access <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                if (state == ST_HS) begin
                    hs_cnt <= hs_cnt + HS_CW'(1);
                end
                if ((state == ST_HS) && (state_nx == ST_IDLE)) begin
                    timeout <= 1'b1;
                end
                if (wr_bad || rd_bad) begin
                    bad_access <= 1'b1;
                end
                if (wr_l0 && (wr_cnt0 != '1)) begin
                    wr_cnt0 <= wr_cnt0 + C0W'(1);
                end
                if (wr_l1 && (wr_cnt1 != '1)) begin
                    wr_cnt1 <= wr_cnt1 + C1W'(1);
                end
            end

            if (rd_l0)       rd_src <= RD_L0;
            else if (rd_l1)  rd_src <= RD_L1;
            else if (rd_bad) rd_src <= RD_ZERO;
            else             rd_src <= RD_NONE;

            if (dmp_l0)      dmp_src <= RD_L0;
            else if (dmp_l1) dmp_src <= RD_L1;
            else             dmp_src <= RD_NONE;
        end
    end

    // Banks share one read port between CONV and readback, so each output
    // keeps its own hold copy and shows the fresh RAM word only after its own read
    always_comb begin
        cdata_rd = cdata_hold;
        case (rd_src)
            RD_L0:   cdata_rd = l0_q;
            RD_L1:   cdata_rd = l1_q;
            RD_ZERO: cdata_rd = '0;
            default: cdata_rd = cdata_hold;
        endcase
    end

    always_comb begin
        dump_data = dump_hold;
        case (dmp_src)
            RD_L0:   dump_data = l0_q;
            RD_L1:   dump_data = l1_q;
            default: dump_data = dump_hold;
        endcase
    end

    // Image ROM: read every cycle, forced to zero whenever the next state is not RUN
    conv_sync_ram #(.W(DW), .AW(AW)) u_img (
        .clk   (clk),
        .rst   (reset || (state_nx != ST_RUN)),
        .we    (ld_en && idle_like),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (1'b1),
        .raddr (iaddr),
        .rdata (img_q)
    );
    assign idata = img_q;

    conv_sync_ram #(.W(DW), .AW(AW)) u_l0 (
        .clk   (clk),
        .rst   (1'b0),
        .we    (wr_l0),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .re    (rd_l0 || dmp_l0),
        .raddr (in_run ? caddr_rd : dump_addr),
        .rdata (l0_q)
    );

    conv_sync_ram #(.W(DW), .AW(L1_AW)) u_l1 (
        .clk   (clk),
        .rst   (1'b0),
        .we    (wr_l1),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .re    (rd_l1 || dmp_l1),
        .raddr (in_run ? caddr_rd[L1_AW-1:0] : dump_addr[L1_AW-1:0]),
        .rdata (l1_q)
    );

endmodule

// File: tb/tb_conv_mem_host.sv
// Scoreboard bench for conv_mem_host: stimulus pushes expected values tagged
// with the cycle they are due; a monitor pops and compares on the falling edge.
module tb_conv_mem_host;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [19:0] ld_data;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        dump_en;
    logic        dump_sel;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        done;
    logic        timeout;
    logic        bad_access;
    logic [12:0] wr_cnt0;
    logic [10:0] wr_cnt1;

    conv_mem_host #(.DW(20), .AW(12), .L1_AW(10), .HS_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .dump_en(dump_en), .dump_sel(dump_sel), .dump_addr(dump_addr),
        .dump_data(dump_data), .done(done), .timeout(timeout),
        .bad_access(bad_access), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SIG_READY = 0;
    localparam int SIG_IDATA = 1;
    localparam int SIG_CDRD  = 2;
    localparam int SIG_DUMP  = 3;
    localparam int SIG_DONE  = 4;
    localparam int SIG_TMO   = 5;
    localparam int SIG_BAD   = 6;
    localparam int SIG_CNT0  = 7;
    localparam int SIG_CNT1  = 8;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        keep[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a value 'off' rising edges from now (0 = state after the latest edge)
    task automatic expect_at(input int off, input int sig, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.due  = cyc + off;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            SIG_READY: return 32'(ready);
            SIG_IDATA: return 32'(idata);
            SIG_CDRD:  return 32'(cdata_rd);
            SIG_DUMP:  return 32'(dump_data);
            SIG_DONE:  return 32'(done);
            SIG_TMO:   return 32'(timeout);
            SIG_BAD:   return 32'(bad_access);
            SIG_CNT0:  return 32'(wr_cnt0);
            SIG_CNT1:  return 32'(wr_cnt1);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle
    initial begin
        forever begin
            @(negedge clk);
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    act = sample(sb[i].sig);
                    if (act !== sb[i].val) begin
                        errors++;
                        $display("FAIL %s: actual=%h expected=%h (cycle %0d)",
                                 sb[i].name, act, sb[i].val, cyc);
                    end
                end else begin
                    keep.push_back(sb[i]);
                end
            end
            sb = keep;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        busy = 1'b0; iaddr = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        crd = 1'b0; caddr_rd = '0; csel = 3'b000; dump_en = 1'b0;
        dump_sel = 1'b0; dump_addr = '0;

        // Reset state
        tick(); tick();
        expect_at(0, SIG_READY, 0, "rst_ready");
        expect_at(0, SIG_DONE,  0, "rst_done");
        expect_at(0, SIG_TMO,   0, "rst_timeout");
        expect_at(0, SIG_BAD,   0, "rst_bad");
        expect_at(0, SIG_CNT0,  0, "rst_cnt0");
        expect_at(0, SIG_CNT1,  0, "rst_cnt1");
        expect_at(0, SIG_IDATA, 0, "rst_idata");
        expect_at(0, SIG_CDRD,  0, "rst_cdata_rd");
        expect_at(0, SIG_DUMP,  0, "rst_dump");
        reset = 1'b0;
        tick();

        // Preload img[k] = k
        for (int k = 0; k < 4096; k++) begin
            ld_en = 1'b1; ld_addr = 12'(k); ld_data = 20'(k);
            tick();
        end
        ld_en = 1'b0;

        // Start handshake; busy rises two cycles after ready
        start = 1'b1;
        expect_at(1, SIG_READY, 1, "hs_ready_up");
        expect_at(2, SIG_READY, 1, "hs_ready_hold");
        tick();
        start = 1'b0;
        tick();
        busy = 1'b1;
        expect_at(1, SIG_READY, 0, "run_ready_drop");
        tick();

        // Image read
        iaddr = 12'h0A5;
        expect_at(1, SIG_IDATA, 32'h000A5, "idata_0a5");
        tick();

        // L0 write then read back
        iaddr = 12'hFFF;
        expect_at(1, SIG_IDATA, 32'h00FFF, "idata_fff");
        csel = 3'b001; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 20'h12345;
        expect_at(1, SIG_CNT0, 1, "cnt0_after_wr");
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd7;
        expect_at(1, SIG_CDRD, 32'h12345, "l0_rd7");
        tick();
        crd = 1'b0;
        expect_at(1, SIG_CDRD, 32'h12345, "cdata_rd_hold");
        tick();

        // L1 read-before-write at address 3
        csel = 3'b011; cwr = 1'b1; caddr_wr = 12'd3; cdata_wr = 20'h00001;
        expect_at(1, SIG_CNT1, 1, "cnt1_first");
        tick();
        cdata_wr = 20'h0ABCD; crd = 1'b1; caddr_rd = 12'd3;
        expect_at(1, SIG_CDRD, 32'h00001, "l1_rbw_old");
        expect_at(1, SIG_CNT1, 2, "cnt1_second");
        tick();
        cwr = 1'b0;
        expect_at(1, SIG_CDRD, 32'h0ABCD, "l1_rd_new");
        tick();
        crd = 1'b0;

        // Illegal csel and out-of-range L1 address
        csel = 3'b010; cwr = 1'b1; caddr_wr = 12'd3; cdata_wr = 20'h55555;
        expect_at(1, SIG_BAD,  1, "bad_csel_wr");
        expect_at(1, SIG_CNT0, 1, "cnt0_unchanged");
        expect_at(1, SIG_CNT1, 2, "cnt1_unchanged_a");
        tick();
        csel = 3'b011; caddr_wr = 12'h403; cdata_wr = 20'h77777;
        expect_at(1, SIG_CNT1, 2, "cnt1_unchanged_b");
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd3;
        expect_at(1, SIG_CDRD, 32'h0ABCD, "l1_no_alias_write");
        tick();
        caddr_rd = 12'h403;
        expect_at(1, SIG_CDRD, 0, "l1_oor_read_zero");
        tick();
        crd = 1'b0; csel = 3'b000;

        // End of run
        busy = 1'b0;
        expect_at(1, SIG_DONE,  1, "done_pulse");
        expect_at(1, SIG_IDATA, 0, "idata_zero_after_run");
        expect_at(2, SIG_DONE,  0, "done_one_cycle");
        tick(); tick();

        // Readback in DONE
        dump_en = 1'b1; dump_sel = 1'b1; dump_addr = 12'd3;
        expect_at(1, SIG_DUMP, 32'h0ABCD, "dump_l1_3");
        expect_at(1, SIG_CDRD, 0, "cdata_rd_untouched_by_dump");
        expect_at(1, SIG_CNT0, 1, "cnt0_after_run");
        expect_at(1, SIG_CNT1, 2, "cnt1_after_run");
        expect_at(1, SIG_BAD,  1, "bad_sticky");
        tick();
        dump_sel = 1'b0; dump_addr = 12'd7;
        expect_at(1, SIG_DUMP, 32'h12345, "dump_l0_7");
        tick();
        dump_en = 1'b0;
        expect_at(1, SIG_DUMP, 32'h12345, "dump_hold");
        tick();

        // Handshake timeout: ready high for exactly 16 cycles
        start = 1'b1;
        for (int k = 1; k <= 16; k++) expect_at(k, SIG_READY, 1, "to_ready_high");
        expect_at(17, SIG_READY, 0, "to_ready_low");
        expect_at(17, SIG_TMO,   1, "to_timeout_set");
        expect_at(1,  SIG_TMO,   0, "hs_timeout_clear");
        expect_at(1,  SIG_BAD,   0, "hs_bad_clear");
        expect_at(1,  SIG_CNT0,  0, "hs_cnt0_clear");
        expect_at(1,  SIG_CNT1,  0, "hs_cnt1_clear");
        tick();
        start = 1'b0;
        ld_en = 1'b1; ld_addr = 12'h0A5; ld_data = 20'h99999;
        dump_en = 1'b1; dump_sel = 1'b1; dump_addr = 12'd3;
        expect_at(1, SIG_DUMP, 32'h12345, "dump_ignored_in_hs");
        tick();
        ld_en = 1'b0; dump_en = 1'b0;
        repeat (17) tick();

        // New run from IDLE, then reset mid-run
        start = 1'b1;
        expect_at(1, SIG_READY, 1, "run2_ready");
        tick();
        start = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        iaddr = 12'h0A5;
        csel = 3'b001; cwr = 1'b1; caddr_wr = 12'd9; cdata_wr = 20'h00042;
        expect_at(1, SIG_IDATA, 32'h000A5, "preload_ignored_in_hs");
        expect_at(1, SIG_CNT0,  1, "run2_cnt0");
        tick();
        cwr = 1'b0;
        reset = 1'b1;
        expect_at(1, SIG_READY, 0, "midrst_ready");
        expect_at(1, SIG_DONE,  0, "midrst_done");
        expect_at(1, SIG_CNT0,  0, "midrst_cnt0");
        expect_at(1, SIG_CNT1,  0, "midrst_cnt1");
        expect_at(1, SIG_IDATA, 0, "midrst_idata");
        expect_at(1, SIG_DUMP,  0, "midrst_dump");
        tick();
        reset = 1'b0; busy = 1'b0; csel = 3'b000;
        dump_en = 1'b1; dump_sel = 1'b0; dump_addr = 12'd9;
        expect_at(1, SIG_DUMP, 32'h00042, "mem_kept_after_reset");
        tick();
        dump_en = 1'b0;
        repeat (3) tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
